// File: rtl/uart_rx.sv
// uart_rx: UART receive core; deserialises rxd into 8/9-bit words and writes them to the RX FIFO.
// Latency: rf_write in the cycle after the last stop-bit sample (one cycle later with majority voting).
// Backpressure: none on the line; rf_full at delivery drops the word and sets the sticky error flag.
// Optional feature: define UART_RX_MAJORITY_EN for 2-of-3 majority voting around each bit centre.
module uart_rx #(
    parameter int SYNC_STAGES = 2  // must be >= 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr_n,
    input  logic [23:0] ckdiv,
    input  logic        data9b,
    input  logic        stop2b,
    input  logic [7:0]  totime,
    input  logic        rxd,
    output logic        rf_write,
    output logic [8:0]  rf_wbyte,
    input  logic        rf_full,
    output logic        error,
    output logic        timeout
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        DATA    = 3'd2,
        STOP1   = 3'd3,
        STOP2   = 3'd4,
        DELIVER = 3'd5
    } state_t;

    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   rxd_s;
    logic                   prev_q, prev_d;

    logic [23:0] cnt_q, cnt_d;
    logic [23:0] ckdiv_l_q, ckdiv_l_d;
    logic        data9b_l_q, data9b_l_d;
    logic        stop2b_l_q, stop2b_l_d;
    logic [3:0]  bitn_q, bitn_d;
    logic [8:0]  shreg_q, shreg_d;
    logic [8:0]  wbyte_q, wbyte_d;
    logic        error_q, error_d;
    logic        timeout_q, timeout_d;
    logic        armed_q, armed_d;
    logic [23:0] tcnt_q, tcnt_d;
    logic [7:0]  tbits_q, tbits_d;

    logic [23:0] half;
    logic [23:0] start_last;
    logic [23:0] bit_last;
    logic [3:0]  bits_last;
    logic [7:0]  tbits_inc;
    logic [8:0]  word;
    logic        bit_val;
    logic        bit_tick;
    logic        start_det;

    // Synchroniser shift: rxd enters at bit 0, rxd_s leaves from the top stage
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], rxd};
    end

    assign rxd_s = sync_q[SYNC_STAGES-1];

`ifdef UART_RX_MAJORITY_EN
    // Two previous rxd_s samples give centre-1 and centre when deciding at centre+1
    logic [1:0] hist_q, hist_d;

    // Sample history for the majority vote
    always_comb begin
        hist_d = {hist_q[0], rxd_s};
    end

    // History register; idles high like the line
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_q <= 2'b11;
        end else begin
            hist_q <= hist_d;
        end
    end

    assign bit_val    = (hist_q[1] & hist_q[0]) | (hist_q[1] & rxd_s) | (hist_q[0] & rxd_s);
    // Start decision one cycle after the centre so later bits stay on the same spacing
    assign start_last = half;
`else
    assign bit_val    = rxd_s;
    assign start_last = half - 24'd1;
`endif

    assign half      = {1'b0, ckdiv_l_q[23:1]};
    assign bit_last  = ckdiv_l_q - 24'd1;
    assign bits_last = data9b_l_q ? 4'd8 : 4'd7;
    assign bit_tick  = (state_q == START) ? (cnt_q == start_last) : (cnt_q == bit_last);
    // Falling edge after a high cycle; a held-low line (break) never re-triggers
    assign start_det = (state_q == IDLE) && prev_q && !rxd_s;
    assign tbits_inc = tbits_q + 8'd1;
    // In 8-bit mode the word was shifted in one position short of the top
    assign word      = data9b_l_q ? shreg_q : {1'b0, shreg_q[8:1]};

    // Frame FSM, word assembly, delivery, error flag and idle timeout
    always_comb begin
        state_d    = state_q;
        prev_d     = rxd_s;
        cnt_d      = cnt_q;
        ckdiv_l_d  = ckdiv_l_q;
        data9b_l_d = data9b_l_q;
        stop2b_l_d = stop2b_l_q;
        bitn_d     = bitn_q;
        shreg_d    = shreg_q;
        wbyte_d    = wbyte_q;
        error_d    = error_q;
        timeout_d  = 1'b0;
        armed_d    = armed_q;
        tcnt_d     = tcnt_q;
        tbits_d    = tbits_q;
        rf_write   = 1'b0;
        rf_wbyte   = wbyte_q;

        case (state_q)
            IDLE: begin
                if (start_det) begin
                    // Frame configuration is frozen here for the whole frame
                    ckdiv_l_d  = ckdiv;
                    data9b_l_d = data9b;
                    stop2b_l_d = stop2b;
                    cnt_d      = 24'd0;
                    bitn_d     = 4'd0;
                    shreg_d    = 9'd0;
                    tcnt_d     = 24'd0;
                    tbits_d    = 8'd0;
                    state_d    = START;
                end
            end
            START: begin
                if (bit_tick) begin
                    cnt_d   = 24'd0;
                    // A high start sample is a glitch, not a frame
                    state_d = bit_val ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + 24'd1;
                end
            end
            DATA: begin
                if (bit_tick) begin
                    cnt_d   = 24'd0;
                    shreg_d = {bit_val, shreg_q[8:1]};
                    if (bitn_q == bits_last) begin
                        bitn_d  = 4'd0;
                        state_d = STOP1;
                    end else begin
                        bitn_d = bitn_q + 4'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 24'd1;
                end
            end
            STOP1: begin
                if (bit_tick) begin
                    cnt_d = 24'd0;
                    if (!bit_val) begin
                        error_d = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = stop2b_l_q ? STOP2 : DELIVER;
                    end
                end else begin
                    cnt_d = cnt_q + 24'd1;
                end
            end
            STOP2: begin
                if (bit_tick) begin
                    cnt_d = 24'd0;
                    if (!bit_val) begin
                        error_d = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = DELIVER;
                    end
                end else begin
                    cnt_d = cnt_q + 24'd1;
                end
            end
            DELIVER: begin
                if (!rf_full) begin
                    rf_write = 1'b1;
                    rf_wbyte = word;
                    wbyte_d  = word;
                end else begin
                    error_d = 1'b1;
                end
                // This cycle counts as the first of the first idle bit period
                armed_d = 1'b1;
                tcnt_d  = 24'd1;
                tbits_d = 8'd0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Idle bit-period counter for the receive timeout
        if ((state_q == IDLE) && armed_q && !start_det && (totime != 8'd0)) begin
            if (tcnt_q >= bit_last) begin
                tcnt_d  = 24'd0;
                tbits_d = tbits_inc;
                if (tbits_inc >= totime) begin
                    timeout_d = 1'b1;
                    armed_d   = 1'b0;
                end
            end else begin
                tcnt_d = tcnt_q + 24'd1;
            end
        end

        // Soft clear holds the receiver idle; the synchroniser keeps running
        if (!clr_n) begin
            state_d    = IDLE;
            prev_d     = 1'b0;
            cnt_d      = 24'd0;
            ckdiv_l_d  = 24'd0;
            data9b_l_d = 1'b0;
            stop2b_l_d = 1'b0;
            bitn_d     = 4'd0;
            shreg_d    = 9'd0;
            wbyte_d    = 9'd0;
            error_d    = 1'b0;
            timeout_d  = 1'b0;
            armed_d    = 1'b0;
            tcnt_d     = 24'd0;
            tbits_d    = 8'd0;
            rf_write   = 1'b0;
            rf_wbyte   = wbyte_q;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            sync_q     <= '1;
            prev_q     <= 1'b0;
            cnt_q      <= 24'd0;
            ckdiv_l_q  <= 24'd0;
            data9b_l_q <= 1'b0;
            stop2b_l_q <= 1'b0;
            bitn_q     <= 4'd0;
            shreg_q    <= 9'd0;
            wbyte_q    <= 9'd0;
            error_q    <= 1'b0;
            timeout_q  <= 1'b0;
            armed_q    <= 1'b0;
            tcnt_q     <= 24'd0;
            tbits_q    <= 8'd0;
        end else begin
            state_q    <= state_d;
            sync_q     <= sync_d;
            prev_q     <= prev_d;
            cnt_q      <= cnt_d;
            ckdiv_l_q  <= ckdiv_l_d;
            data9b_l_q <= data9b_l_d;
            stop2b_l_q <= stop2b_l_d;
            bitn_q     <= bitn_d;
            shreg_q    <= shreg_d;
            wbyte_q    <= wbyte_d;
            error_q    <= error_d;
            timeout_q  <= timeout_d;
            armed_q    <= armed_d;
            tcnt_q     <= tcnt_d;
            tbits_q    <= tbits_d;
        end
    end

    assign error   = error_q;
    assign timeout = timeout_q;

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receive core. Deserialises the rxd pin into 8- or 9-bit words and pushes them into the RX byte_fifo through its write port.
- Sits between the pad and the RX FIFO, and is configured by uart_reg (clr_n, ckdiv, data9b, stop2b, totime).
- Produces the sticky error flag and the receive-timeout pulse that uart_reg reports in SR.

Parameters:
- SYNC_STAGES, 2, number of rxd synchroniser flops (minimum 2).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- clr_n  in  1  synchronous soft clear, active low (CR.ena)
- ckdiv  in  24  clk cycles per bit; uart_reg guarantees the value is at least 16
- data9b  in  1  1 = 9 data bits, 0 = 8 data bits
- stop2b  in  1  1 = 2 stop bits, 0 = 1 stop bit
- totime  in  8  idle timeout in bit periods; 0 = timeout disabled
- rxd  in  1  serial input, asynchronous, idles high
- rf_write  out  1  one-cycle FIFO write strobe
- rf_wbyte  out  9  received word, zero-extended when data9b=0
- rf_full  in  1  RX FIFO full
- error  out  1  sticky framing/overrun error
- timeout  out  1  one-cycle receive-timeout pulse

Behaviour:
- Reset (rst_n low, asynchronous): FSM=IDLE; all counters 0; rf_write=0, rf_wbyte=0, error=0, timeout=0; synchroniser flops=1.
- clr_n low: synchronous clear of everything above except the synchroniser; the FSM is held in IDLE while clr_n is low.
- Synchroniser: rxd_s = rxd delayed SYNC_STAGES cycles. All decisions use rxd_s.
- Start detection: IDLE waits for rxd_s high, then low. The first low cycle is S.
  - At S, latch ckdiv, data9b and stop2b into local copies. These copies are used for the whole frame; configuration changes mid-frame take effect next frame.
  - Enter START with cnt=0 at S+1.
- Bit timing: half = ckdiv_l>>1.
  - START samples when cnt==half-1, which is cycle S+half.
  - If the sample is 1, the start is false: return to IDLE, no error.
  - If the sample is 0, enter DATA with cnt=0.
  - DATA, STOP1 and STOP2 each sample when cnt==ckdiv_l-1, then reset cnt to 0. Samples therefore fall on bit centres S+half+k*ckdiv_l.
- DATA: LSB first. 8 or 9 bits, counted by a bit counter. Next state is STOP1.
- STOP1:
  - Sample 0: set error, drop the word, go to IDLE (STOP2 skipped).
  - Sample 1: go to STOP2 if stop2b_l, else go to DELIVER.
- STOP2:
  - Sample 0: set error, drop the word, go to IDLE.
  - Sample 1: go to DELIVER.
- DELIVER (single cycle), the cycle after the last stop sample:
  - If rf_full=0: rf_write=1 and rf_wbyte=word.
  - If rf_full=1: overrun; set error, drop the word, rf_write stays 0.
  - Always go to IDLE and arm the timeout.
- rf_wbyte holds its last value when not written. Bit 8 is 0 in 8-bit mode.
- error: sticky. Cleared only by rst_n or clr_n.
- Timeout:
  - The timeout is armed only after DELIVER (including an overrun drop).
  - While armed and in IDLE, a bit-period counter counts idle bit times.
  - A start detection clears the count. The count resumes after that frame.
  - When the count reaches totime (totime≠0): timeout=1 for one cycle, then disarm.
  - totime=0: never pulse.
- Back-to-back frames: IDLE may detect the next start in the cycle after DELIVER/IDLE entry if rxd_s has been high.
- Break (rxd held low): one framing error, then wait for rxd high. No repeated errors.

Optional Feature:
- Macro: UART_RX_MAJORITY_EN.
- Defined:
  - Each bit is decided by a 2-of-3 majority of rxd_s at centre-1, centre and centre+1.
  - The decision is taken at centre+1 and the following bit's cnt restarts from that point, so bit spacing stays ckdiv_l.
  - DELIVER moves one cycle later.
- Undefined: single sample at centre, as above.

Test Plan:
- ckdiv=16, 8N1, clean 0xA5, rxd falls at T → rf_write exactly at T+155 (T+156 with majority), rf_wbyte=0x0A5, error=0.
- ckdiv=16, data9b=1, stop2b=1, word 0x1C3 → single rf_write, rf_wbyte=0x1C3. A second frame starting immediately after the second stop is also received.
- Low glitch of 4 cycles on an idle line → no rf_write, error=0, FSM back in IDLE.
- Stop bit forced 0 on 0x55 → no rf_write, error=1 and stays 1. Pulsing clr_n low clears it.
- rf_full=1 during a valid frame → no rf_write, error=1.
- totime=3, ckdiv=16, one byte then idle → timeout pulses once, 48±1 cycles after DELIVER. With totime=0 there is no pulse. Without a received byte there is no pulse.
